led_strip_driver: RTL and testbench

- Parametrised single-wire serial LED strip driver (WS2812-class NRZ protocol).
- Holds a frame buffer of NUM_LEDS pixel words, each BITS_PER_LED bits wide, writable from a host port.
- On request, serialises one frame MSB-first, then holds the line low for the latch period.
- Supports single-shot and continuous refresh. Sits between the pixel/colour generator and the strip output pin.

---
 rtl/led_strip_driver.sv | 134 +++++++++++++
 tb/tb_led_strip_driver.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_driver.sv
// WS2812-class single-wire NRZ LED strip driver: frame buffer, MSB-first serialiser, latch gap.
// Optional LED_STRIP_BRIGHTNESS_EN scales each 8-bit colour field by a brightness input at pixel load.
module led_strip_driver #(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int BITS_PER_LED = 24,
  parameter int BIT_PERIOD   = 63,
  parameter int T0H          = 20,
  parameter int T1H          = 43,
  parameter int LATCH_CYCLES = 3600
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [BITS_PER_LED-1:0] wr_data,
  input  logic                    start,
  input  logic                    cont,
`ifdef LED_STRIP_BRIGHTNESS_EN
  input  logic [7:0]              brightness,
`endif
  output logic                    busy,
  output logic                    frame_done,
  output logic [ADDR_W-1:0]       led_idx,
  output logic                    dout
);

  localparam int CNT_MAX = (LATCH_CYCLES > BIT_PERIOD) ? LATCH_CYCLES : BIT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;

  localparam logic [ADDR_W:0]   LED_LIMIT  = (ADDR_W+1)'(NUM_LEDS);
  localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BITS_PER_LED - 1);
  localparam logic [CNT_W-1:0]  BP_LAST    = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  T0H_C      = CNT_W'(T0H);
  localparam logic [CNT_W-1:0]  T1H_C      = CNT_W'(T1H);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, LATCH, DONE} state_t;

  state_t                  state;
  logic [BITS_PER_LED-1:0] mem [NUM_LEDS];
  logic [BITS_PER_LED-1:0] shreg;
  logic [BITS_PER_LED-1:0] pix_in;
  logic [BIT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        cyc_cnt;

  // Out-of-range addresses are dropped rather than aliased onto real pixels.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < LED_LIMIT))
      mem[wr_addr] <= wr_data;
  end

`ifdef LED_STRIP_BRIGHTNESS_EN
  always_comb begin
    pix_in = mem[led_idx];
    for (int f = 0; f < BITS_PER_LED / 8; f++)
      pix_in[f*8 +: 8] = 8'(({8'd0, mem[led_idx][f*8 +: 8]} * {8'd0, brightness}) >> 8);
  end
`else
  assign pix_in = mem[led_idx];
`endif

  // dout is the registered image of the SEND-state waveform, so it trails state by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      led_idx    <= '0;
      dout       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
    end else begin
      dout       <= (state == SEND) &&
                    (cyc_cnt < (shreg[BITS_PER_LED-1] ? T1H_C : T0H_C));
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg   <= pix_in;
          bit_cnt <= BIT_LAST;
          cyc_cnt <= '0;
          state   <= SEND;
        end
        SEND: begin
          if (cyc_cnt == BP_LAST) begin
            cyc_cnt <= '0;
            shreg   <= shreg << 1;
            if (bit_cnt == '0) begin
              if (led_idx == IDX_LAST) begin
                state <= LATCH;
              end else begin
                led_idx <= led_idx + ADDR_W'(1);
                state   <= LOAD;
              end
            end else begin
              bit_cnt <= bit_cnt - BIT_W'(1);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          if (cyc_cnt == LATCH_LAST) begin
            cyc_cnt    <= '0;
            led_idx    <= '0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (cont || start) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_driver.sv
// Randomised bench for led_strip_driver: frame-level reference model plus pinned literal frames.
module tb_led_strip_driver;

  localparam int N   = 3;
  localparam int B   = 8;
  localparam int BP  = 5;
  localparam int TL  = 1;
  localparam int TH  = 3;
  localparam int LAT = 4;
  localparam int PP  = B * BP + 1;
  localparam int D   = N * PP + LAT;

`ifdef LED_STRIP_BRIGHTNESS_EN
  logic [7:0] brightness = 8'h80;
  localparam logic [23:0] EXP_A    = 24'h552A7F;
  localparam logic [23:0] EXP_C    = 24'h55077F;
  localparam logic [23:0] EXP_CONT = 24'h55071E;
  localparam logic [23:0] BIG_WR   = 24'hFF4002;
  localparam logic [23:0] BIG_EXP  = 24'h7F2001;
`else
  localparam logic [23:0] EXP_A    = 24'hAA55FF;
  localparam logic [23:0] EXP_C    = 24'hAA0FFF;
  localparam logic [23:0] EXP_CONT = 24'hAA0F3C;
  localparam logic [23:0] BIG_WR   = 24'h800001;
  localparam logic [23:0] BIG_EXP  = 24'h800001;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       s_wr_en = 1'b0, s_start = 1'b0, s_cont = 1'b0;
  logic [1:0] s_wr_addr = '0;
  logic [7:0] s_wr_data = '0;
  logic       s_busy, s_fd, s_dout;
  logic [1:0] s_idx;

  logic        b_wr_en = 1'b0, b_start = 1'b0, b_cont = 1'b0;
  logic [5:0]  b_wr_addr = '0;
  logic [23:0] b_wr_data = '0;
  logic        b_busy, b_fd, b_dout;
  logic [5:0]  b_idx;

  led_strip_driver #(.NUM_LEDS(N), .ADDR_W(2), .BITS_PER_LED(B), .BIT_PERIOD(BP),
                     .T0H(TL), .T1H(TH), .LATCH_CYCLES(LAT)) u_small (
    .clk(clk), .reset(reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .start(s_start), .cont(s_cont),
`ifdef LED_STRIP_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(s_busy), .frame_done(s_fd), .led_idx(s_idx), .dout(s_dout));

  led_strip_driver #(.NUM_LEDS(1)) u_big (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .start(b_start), .cont(b_cont),
`ifdef LED_STRIP_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(b_busy), .frame_done(b_fd), .led_idx(b_idx), .dout(b_dout));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame time t counts cycles from the LOAD of pixel 0 to DONE (t == D).
  bit         m_run = 1'b0;
  int         t = 0;
  logic [7:0] mmem [N];
  logic [7:0] pix  [N];
  int         cyc = 0;
  int         hi_run = 0;
  int         rx_n = 0;
  logic [23:0] rx_bits = '0;
  bit         fd_now = 1'b0;

  function automatic logic [7:0] scl(input logic [7:0] v);
`ifdef LED_STRIP_BRIGHTNESS_EN
    return 8'(({8'd0, v} * {8'd0, brightness}) >> 8);
`else
    return v;
`endif
  endfunction

  // Line level during frame-time s, before the one-cycle output register.
  function automatic logic wave(input int s);
    int p, r, bi, c;
    logic b;
    if (s < 0 || s >= N * PP) return 1'b0;
    p = s / PP;
    r = s % PP;
    if (r == 0) return 1'b0;
    bi = (r - 1) / BP;
    c  = (r - 1) % BP;
    b  = pix[p][B-1-bi];
    return (c < (b ? TH : TL));
  endfunction

  task automatic rx_clear();
    hi_run = 0;
    rx_n = 0;
    rx_bits = '0;
  endtask

  task automatic cycle(input logic st, input logic ct, input logic we,
                       input logic [1:0] wa, input logic [7:0] wd);
    logic [4:0] act, exp;
    int ei;
    @(negedge clk);
    cyc++;
    ei  = !m_run ? 0 : (t < N * PP ? t / PP : (t < D ? N - 1 : 0));
    exp = {m_run, (m_run && t == D), 2'(ei), (m_run ? wave(t - 1) : 1'b0)};
    act = {s_busy, s_fd, s_idx, s_dout};
    chk($sformatf("model t=%0d run=%0d {busy,fd,idx,dout}", t, m_run), 32'(act), 32'(exp));
    fd_now = s_fd;
    if (s_dout) hi_run++;
    else if (hi_run > 0) begin
      rx_bits = {rx_bits[22:0], (hi_run >= TH)};
      rx_n++;
      hi_run = 0;
    end
    if (m_run && t < N * PP && t % PP == 0) pix[t / PP] = scl(mmem[t / PP]);
    s_start = st; s_cont = ct; s_wr_en = we; s_wr_addr = wa; s_wr_data = wd;
    if (we && int'(wa) < N) mmem[wa] = wd;
    if (m_run) begin
      if (t == D) begin
        if (ct || st) t = 0;
        else m_run = 1'b0;
      end else t++;
    end else if (st) begin
      m_run = 1'b1;
      t = 0;
    end
  endtask

  // Single-shot frame; optional write on iteration wi (iteration 42 is pixel 1's LOAD cycle).
  task automatic run_frame(input int wi, input logic [1:0] wa, input logic [7:0] wd,
                           output int flen);
    int st_c, fd_c;
    rx_clear();
    fd_c = -1;
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    st_c = cyc;
    for (int i = 1; i <= 135; i++) begin
      cycle(1'b0, 1'b0, (i == wi), wa, wd);
      if (fd_now && fd_c < 0) fd_c = cyc;
    end
    flen = fd_c - st_c;
  endtask

  initial begin
    int flen, n_fd, last_fd, bad_per, busy_low;
    logic [23:0] first_rx;
    bit cont_r;
    int b_run, b_n, b_bad, b_rise, b_fdt, b_fdn, b_busy_after;
    logic [23:0] b_bits;

    #2 reset = 1'b0;
    #1;
    chk("reset dout", 32'(s_dout), 32'd0);
    chk("reset busy", 32'(s_busy), 32'd0);
    chk("reset frame_done", 32'(s_fd), 32'd0);
    chk("reset led_idx", 32'(s_idx), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    reset = 1'b1;

    cycle(1'b0, 1'b0, 1'b1, 2'd0, 8'hAA);
    cycle(1'b0, 1'b0, 1'b1, 2'd1, 8'h55);
    cycle(1'b0, 1'b0, 1'b1, 2'd2, 8'hFF);
    cycle(1'b0, 1'b0, 1'b1, 2'd3, 8'h00);

    run_frame(-1, 2'd0, 8'd0, flen);
    chk("frame A length", 32'(flen), 32'd128);
    chk("frame A stream", 32'(rx_bits), 32'(EXP_A));
    chk("frame A bit count", 32'(rx_n), 32'd24);

    run_frame(42, 2'd1, 8'h0F, flen);
    chk("load-cycle write old stream", 32'(rx_bits), 32'(EXP_A));
    run_frame(-1, 2'd0, 8'd0, flen);
    chk("load-cycle write new stream", 32'(rx_bits), 32'(EXP_C));
    chk("frame C length", 32'(flen), 32'd128);

    rx_clear();
    n_fd = 0; last_fd = 0; bad_per = 0; busy_low = 0; first_rx = '0;
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    for (int i = 1; i <= 400; i++) begin
      cycle(1'b0, 1'b1, (i == 10), 2'd2, 8'h3C);
      if (!s_busy) busy_low++;
      if (fd_now) begin
        if (n_fd == 0) first_rx = rx_bits;
        else if (cyc - last_fd != 128) bad_per++;
        last_fd = cyc;
        n_fd++;
      end
    end
    chk("cont busy low cycles", 32'(busy_low), 32'd0);
    chk("cont frame_done count", 32'(n_fd), 32'd3);
    chk("cont bad periods", 32'(bad_per), 32'd0);
    chk("cont same-frame write stream", 32'(first_rx), 32'(EXP_CONT));
    for (int i = 0; i < 130; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort dout", 32'(s_dout), 32'd0);
    chk("abort busy", 32'(s_busy), 32'd0);
    m_run = 1'b0;
    t = 0;
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    reset = 1'b1;
    run_frame(-1, 2'd0, 8'd0, flen);
    chk("post-abort stream", 32'(rx_bits), 32'(EXP_CONT));
    chk("post-abort length", 32'(flen), 32'd128);

    cont_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) cont_r = !cont_r;
      cycle(($urandom_range(0, 24) == 0), cont_r, ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 8'($urandom));
    end
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Default timing, one pixel.
    @(negedge clk);
    b_wr_en = 1'b1; b_wr_addr = 6'd0; b_wr_data = BIG_WR;
    @(negedge clk);
    b_wr_en = 1'b0; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_run = 0; b_n = 0; b_bad = 0; b_rise = -1; b_fdt = -1; b_fdn = 0; b_busy_after = -1;
    b_bits = '0;
    for (int i = 0; i < 6000; i++) begin
      if (i > 0) @(negedge clk);
      if (b_dout && b_rise < 0) b_rise = i;
      if (b_dout) b_run++;
      else if (b_run > 0) begin
        b_bits = {b_bits[22:0], (b_run == 43)};
        if (b_run != 20 && b_run != 43) b_bad++;
        b_n++;
        b_run = 0;
      end
      if (b_fd) begin
        b_fdn++;
        if (b_fdt < 0) b_fdt = i;
      end
      if (b_fdt >= 0 && i == b_fdt + 1) b_busy_after = int'(b_busy);
      if (b_fdt >= 0 && i > b_fdt + 2) break;
    end
    chk("big start latency", 32'(b_rise), 32'd2);
    chk("big word", 32'(b_bits), 32'(BIG_EXP));
    chk("big bit count", 32'(b_n), 32'd24);
    chk("big bad pulse widths", 32'(b_bad), 32'd0);
    chk("big frame_done time", 32'(b_fdt), 32'd5113);
    chk("big frame_done pulses", 32'(b_fdn), 32'd1);
    chk("big busy after done", 32'(b_busy_after), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
